// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch path: memory map defaults, read/write encoding,
// FSM states, queue entry layout and the PC legality rule.
package fetch_unit_pkg;

    localparam logic        READ                 = 1'b0;
    localparam logic [31:0] DEF_STARTING_ADDR    = 32'h0100_0000;
    localparam logic [31:0] DEF_MEM_DEPTH_BYTES  = 32'h0010_0000;
    localparam int          DEF_QUEUE_DEPTH      = 2;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_FULL  = 2'd1,
        S_FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } queue_entry_t;

    // Offset form keeps the upper-bound compare free of base+depth overflow.
    function automatic logic pc_is_legal(
        input logic [31:0] pc,
        input logic [31:0] base,
        input logic [31:0] depth
    );
        logic [31:0] offset;
        offset = pc - base;
        return (pc[1:0] == 2'b00) && (pc >= base) && (offset <= depth - 32'd4);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO for fetched {pc, word} entries; flush beats push/pop.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            // NOTE: storage is reset only because the head word must read as zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads mainmem combinationally, queues {pc, word}
// for decode, honours execute redirects and stops fetching on an illegal PC.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] STARTING_ADDR   = DEF_STARTING_ADDR,
    parameter logic [31:0] MEM_DEPTH_BYTES = DEF_MEM_DEPTH_BYTES,
    parameter int          QUEUE_DEPTH     = DEF_QUEUE_DEPTH
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] mem_address,
    output logic        mem_read_write,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        fault
);
    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  w_pc_seq;
    logic         w_full;
    logic         w_empty;
    logic         w_pop;
    logic         w_push_ok;
    logic         w_push;
    logic         w_flush;
    logic         w_fifo_pop;
    queue_entry_t w_head;
    queue_entry_t w_new_entry;

    assign mem_address    = r_pc;
    assign mem_read_write = READ;
    assign mem_data_in    = 32'h0;

    assign inst_valid  = !w_empty;
    assign inst        = w_head.word;
    assign inst_pc     = w_head.pc;
    assign fault       = (r_state == S_FAULT);

    assign w_pop       = inst_valid && inst_ready;
    assign w_push_ok   = !w_full || w_pop;
    assign w_pc_seq    = r_pc + 32'd4;
    assign w_new_entry = '{pc: r_pc, word: mem_data_out};

    fetch_queue #(
        .WIDTH (64),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .i_clock (clock),
        .i_reset (reset),
        .i_push  (w_push),
        .i_pop   (w_fifo_pop),
        .i_flush (w_flush),
        .i_wdata (w_new_entry),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_pc    <= STARTING_ADDR;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_push       = 1'b0;
        w_flush      = 1'b0;
        w_fifo_pop   = w_pop;
        case (r_state)
            S_FETCH, S_FULL: begin
                if (redirect_valid) begin
                    // An illegal target only faults; the queued work still drains.
                    if (pc_is_legal(redirect_pc, STARTING_ADDR, MEM_DEPTH_BYTES)) begin
                        w_flush      = 1'b1;
                        w_fifo_pop   = 1'b0;
                        w_pc_next    = redirect_pc;
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_FAULT;
                    end
                end else if (w_push_ok) begin
                    w_push = 1'b1;
                    if (pc_is_legal(w_pc_seq, STARTING_ADDR, MEM_DEPTH_BYTES)) begin
                        w_pc_next    = w_pc_seq;
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_FAULT;
                    end
                end else begin
                    w_state_next = S_FULL;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
